// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register-file read, writeback bypass, immediate/control
// decode, load-use hazard stall and the ID/EX pipeline register with valid/ready and flush.
module id_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rf_read_reg1,
    output logic [4:0]      rf_read_reg2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_write_reg,
    input  logic [XLEN-1:0] wb_write_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            funct7b5_q, funct7b5_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            branch_q, branch_d;
    logic            jump_q, jump_d;
    logic            illegal_q, illegal_d;

    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_uses_rs1, dec_uses_rs2;
    logic [31:0]     dec_imm32;
    logic            dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_illegal;
    logic [XLEN-1:0] byp1, byp2;
    logic            hazard, advance;

    assign dec_opcode   = in_instr[6:0];
    assign dec_rd       = in_instr[11:7];
    assign dec_rs1      = in_instr[19:15];
    assign dec_rs2      = in_instr[24:20];
    assign rf_read_reg1 = dec_rs1;
    assign rf_read_reg2 = dec_rs2;

    // Opcode decode: immediate format, register usage and control bits.
    always_comb begin
        dec_imm32     = 32'h0;
        dec_uses_rs1  = 1'b1;
        dec_uses_rs2  = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        unique case (dec_opcode)
            OP_LUI, OP_AUIPC: begin
                dec_imm32     = {in_instr[31:12], 12'h0};
                dec_uses_rs1  = 1'b0;
                dec_reg_write = 1'b1;
            end
            OP_JAL: begin
                dec_imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
                dec_uses_rs1  = 1'b0;
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
            end
            OP_JALR: begin
                dec_imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
                dec_uses_rs2 = 1'b1;
                dec_branch   = 1'b1;
            end
            OP_LOAD: begin
                dec_imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_STORE: begin
                dec_imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec_uses_rs2  = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_IMM: begin
                dec_imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_reg_write = 1'b1;
            end
            OP_OP: begin
                dec_uses_rs2  = 1'b1;
                dec_reg_write = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_rd == 5'd0) dec_reg_write = 1'b0;
    end

    // Register file writes at the edge, so a same-cycle writeback must be forwarded.
    always_comb begin
        byp1 = rf_read_data1;
        byp2 = rf_read_data2;
        if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == dec_rs1)) byp1 = wb_write_data;
        if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == dec_rs2)) byp2 = wb_write_data;
        if (dec_rs1 == 5'd0) byp1 = '0;
        if (dec_rs2 == 5'd0) byp2 = '0;
    end

    assign hazard   = valid_q && mem_read_q && (rd_q != 5'd0) &&
                      ((dec_uses_rs1 && (dec_rs1 == rd_q)) || (dec_uses_rs2 && (dec_rs2 == rd_q)));
    assign advance  = !valid_q || out_ready;
    assign in_ready = rst_n && advance && !hazard && !flush;

    // ID/EX next state: flush, capture/bubble on advance, operand refresh while held.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        imm_d       = imm_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        funct7b5_d  = funct7b5_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        branch_d    = branch_q;
        jump_d      = jump_q;
        illegal_d   = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            if (in_valid && in_ready) begin
                valid_d     = 1'b1;
                pc_d        = in_pc;
                rs1_d       = dec_rs1;
                rs2_d       = dec_rs2;
                rd_d        = dec_rd;
                rs1_val_d   = byp1;
                rs2_val_d   = byp2;
                imm_d       = XLEN'($signed(dec_imm32));
                opcode_d    = dec_opcode;
                funct3_d    = in_instr[14:12];
                funct7b5_d  = in_instr[30];
                reg_write_d = dec_reg_write;
                mem_read_d  = dec_mem_read;
                mem_write_d = dec_mem_write;
                branch_d    = dec_branch;
                jump_d      = dec_jump;
                illegal_d   = dec_illegal;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rs1_q)) rs1_val_d = wb_write_data;
            if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rs2_q)) rs2_val_d = wb_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= PC_RESET;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7b5_q  <= funct7b5_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            jump_q      <= jump_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_rs1       = rs1_q;
    assign out_rs2       = rs2_q;
    assign out_rd        = rd_q;
    assign out_rs1_val   = rs1_val_q;
    assign out_rs2_val   = rs2_val_q;
    assign out_imm       = imm_q;
    assign out_opcode    = opcode_q;
    assign out_funct3    = funct3_q;
    assign out_funct7b5  = funct7b5_q;
    assign out_reg_write = reg_write_q;
    assign out_mem_read  = mem_read_q;
    assign out_mem_write = mem_write_q;
    assign out_branch    = branch_q;
    assign out_jump      = jump_q;
    assign out_illegal   = illegal_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode pipeline stage between the fetch buffer and execute.
- Drives the register file's two combinational read addresses and consumes its read data.
- Bypasses the same-cycle writeback value, because the register file writes at the clock edge while its reads are combinational.
- Decodes RV32I fields and immediates, detects load-use hazards, and registers everything into the ID/EX pipeline register with a valid/ready handshake and flush.

Parameters:
XLEN, 32, datapath width (register file data and PC width)
PC_RESET, 32'h0, reset value of out_pc

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage accepts in_instr this cycle
in_pc  input  XLEN  PC of in_instr
in_instr  input  32  raw instruction
rf_read_reg1  output  5  = in_instr[19:15], combinational
rf_read_reg2  output  5  = in_instr[24:20], combinational
rf_read_data1  input  XLEN  register file data for rf_read_reg1 (x0 reads 0)
rf_read_data2  input  XLEN  register file data for rf_read_reg2
wb_reg_write  input  1  writeback commits this cycle (same signal feeding the register file)
wb_write_reg  input  5  writeback destination
wb_write_data  input  XLEN  writeback value
flush  input  1  kill the ID/EX contents and the incoming instruction
out_valid  output  1  ID/EX register holds a valid instruction
out_ready  input  1  execute accepts the ID/EX contents
out_pc  output  XLEN  registered PC
out_rs1, out_rs2, out_rd  output  5 each  registered register indices
out_rs1_val, out_rs2_val  output  XLEN each  registered operand values
out_imm  output  XLEN  sign-extended immediate
out_opcode  output  7  instr[6:0]
out_funct3  output  3  instr[14:12]
out_funct7b5  output  1  instr[30]
out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  output  1 each  decoded controls
out_illegal  output  1  unsupported opcode

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_pc=PC_RESET; all other out_* = 0.
  - in_ready is combinational and evaluates to 0 while rst_n=0.
- advance = !out_valid || out_ready.
- hazard (load-use):
  - Condition: out_valid && out_mem_read && out_rd!=0, and the incoming instruction uses rs1 with rs1==out_rd, or uses rs2 with rs2==out_rd.
  - rs1 is used by all opcodes except LUI, AUIPC and JAL. rs2 is used by R-type, STORE and BRANCH only.
- in_ready = advance && !hazard && !flush.
- On a clk edge with advance=1:
  - in_valid && in_ready: capture the decoded instruction and set out_valid=1.
  - Otherwise: out_valid=0 (bubble), and other out_* hold. During a hazard this inserts exactly one bubble.
- Priority: flush > advance. When flush=1, out_valid<=0 next edge regardless of out_ready, and the incoming instruction is dropped (in_ready=0).
- Operand bypass at capture, per source:
  - If wb_reg_write && wb_write_reg!=0 && wb_write_reg==rsN, use wb_write_data.
  - Otherwise use rf_read_dataN.
  - rsN==0 always yields 0.
- Held-operand refresh: while out_valid && !out_ready, if wb_reg_write && wb_write_reg!=0 && wb_write_reg==out_rsN, then out_rsN_val <= wb_write_data. No other out_* field changes while held.
- Immediates (sign-extended from instr[31]):
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI/AUIPC, low 12 bits 0.
  - J: JAL, bit0=0.
  - Any other opcode: out_imm=0.
- Controls:
  - reg_write: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR.
  - mem_read: LOAD. mem_write: STORE.
  - branch: BRANCH. jump: JAL, JALR.
  - Unknown opcode: out_illegal=1, all controls 0, out_valid=1; execute raises the trap.
- out_reg_write is forced 0 when rd==0.
- Latency: 1 cycle from in_valid&&in_ready to out_valid.
- Throughput: 1 instruction/cycle absent stalls.
- Reset mid-stall: rst_n=0 overrides hold, flush and hazard; contents are discarded.

Test Plan:
- Back-to-back ADDI x1,x0,5 then ADDI x2,x0,7 with out_ready=1 -> out_valid on consecutive cycles; out_imm=5 then 7; out_rd=1 then 2.
- Instruction reads x3 in the same cycle wb writes x3=32'hDEADBEEF while rf_read_data1=0 -> out_rs1_val=32'hDEADBEEF. Same case with wb_write_reg=0 and rs1=0 -> out_rs1_val=0.
- LW x5,0(x1) followed by ADD x6,x5,x2 -> ADD stalls: in_ready=0 for exactly 1 cycle, one bubble (out_valid=0), then ADD issues. Same sequence with ADD x6,x2,x7 -> no stall.
- out_ready=0 for 3 cycles holding SUB x4,x8,x9 while wb writes x9=32'h12 -> out_rs2_val becomes 32'h12; all other outputs stable; in_ready=0.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming instruction dropped; a flush concurrent with a hazard still yields out_valid=0.
- BEQ with offset -4, JAL with offset +2048, and opcode 7'h7F -> out_imm=32'hFFFFFFFC; out_imm=32'h00000800; out_illegal=1 with all controls 0.
